// File: rtl/soc_pkg.sv
// Shared definitions for the call/return path.
// Contents:
//   ADDR_W      return-address / stack data width
//   DEPTH       return-address buffer entries (power of two)
//   PTR_W       log2(DEPTH)
//   INITIAL_SP  stack pointer value the stack controller starts from
//   seq_state_e sequencer FSM states
package soc_pkg;

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned PTR_W  = 4;

    localparam logic [ADDR_W-1:0] INITIAL_SP = 19'h1FFFF;

    typedef enum logic [0:0] {
        S_IDLE,
        S_RESP
    } seq_state_e;

endpackage

// File: rtl/ras_regfile.sv
// Return-address storage: DEPTH x ADDR_W, one synchronous write port and one
// asynchronous read port. Storage is not reset; the valid-entry count kept by
// the sequencer decides which entries are meaningful.
// Ports:
//   clk    system clock
//   we     write enable
//   waddr  write index
//   wdata  write data
//   raddr  read index
//   rdata  read data (combinational)
module ras_regfile #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned PTR_W  = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [ADDR_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [ADDR_W-1:0] rdata
);

    logic [ADDR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/call_ret_sequencer.sv
// Call/return sequencer sitting between decode and the stack controller.
// Accepts CALL/RET requests over valid/ready, keeps a circular LIFO of return
// addresses, emits one-cycle call/ret pulses that step the stack controller's
// SP, and hands the popped address to fetch through a registered response.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   req_valid/req_ready      request handshake
//   req_call/req_ret         request kind (both set: request is dropped)
//   req_addr                 return address pushed on CALL
//   flush                    empties the buffer, cancels a pending response
//   rsp_valid/rsp_ready      response handshake
//   rsp_addr/rsp_miss        popped address, or miss on empty buffer
//   call/ret                 one-cycle SP step pulses
//   depth_cnt                valid entries, 0..DEPTH
//   ovf                      sticky: a push overwrote the oldest entry
module call_ret_sequencer
    import soc_pkg::*;
#(
    parameter int unsigned ADDR_W = soc_pkg::ADDR_W,
    parameter int unsigned DEPTH  = soc_pkg::DEPTH,
    parameter int unsigned PTR_W  = soc_pkg::PTR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_call,
    input  logic              req_ret,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              flush,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_miss,
    output logic              call,
    output logic              ret,
    output logic [PTR_W:0]    depth_cnt,
    output logic              ovf
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);

    seq_state_e        state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    depth_q, depth_d;
    logic              ovf_q, ovf_d;
    logic              call_q, call_d;
    logic              ret_q, ret_d;
    logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
    logic              rsp_miss_q, rsp_miss_d;

    logic              accept;
    logic              do_call;
    logic              do_ret;
    logic [PTR_W-1:0]  rd_ptr;
    logic [ADDR_W-1:0] rd_data;

    assign req_ready = (state_q == S_IDLE) && !flush;
    assign accept    = req_valid && req_ready;
    // Simultaneous call+ret is accepted but acts on nothing.
    assign do_call   = accept && req_call && !req_ret;
    assign do_ret    = accept && req_ret && !req_call;
    // Top of stack sits just below the write pointer.
    assign rd_ptr    = wr_ptr_q - PTR_ONE;

    ras_regfile #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_regfile (
        .clk    (clk),
        .we     (do_call),
        .waddr  (wr_ptr_q),
        .wdata  (req_addr),
        .raddr  (rd_ptr),
        .rdata  (rd_data)
    );

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        depth_d    = depth_q;
        ovf_d      = ovf_q;
        call_d     = 1'b0;
        ret_d      = 1'b0;
        rsp_addr_d = rsp_addr_q;
        rsp_miss_d = rsp_miss_q;

        if (flush) begin
            wr_ptr_d = '0;
            depth_d  = '0;
            state_d  = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (do_call) begin
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        call_d   = 1'b1;
                        // Full buffer: the push wraps onto the oldest entry.
                        if (depth_q == FULL_CNT) begin
                            ovf_d = 1'b1;
                        end else begin
                            depth_d = depth_q + CNT_ONE;
                        end
                    end else if (do_ret) begin
                        state_d = S_RESP;
                        if (depth_q != '0) begin
                            wr_ptr_d   = rd_ptr;
                            depth_d    = depth_q - CNT_ONE;
                            rsp_addr_d = rd_data;
                            rsp_miss_d = 1'b0;
                            ret_d      = 1'b1;
                        end else begin
                            rsp_addr_d = '0;
                            rsp_miss_d = 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            depth_q    <= '0;
            ovf_q      <= 1'b0;
            call_q     <= 1'b0;
            ret_q      <= 1'b0;
            rsp_addr_q <= '0;
            rsp_miss_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            depth_q    <= depth_d;
            ovf_q      <= ovf_d;
            call_q     <= call_d;
            ret_q      <= ret_d;
            rsp_addr_q <= rsp_addr_d;
            rsp_miss_q <= rsp_miss_d;
        end
    end

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_addr  = rsp_addr_q;
    assign rsp_miss  = rsp_miss_q;
    assign call      = call_q;
    assign ret       = ret_q;
    assign depth_cnt = depth_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_call_ret_sequencer.sv
// Bench for call_ret_sequencer: directed scenarios plus random traffic checked
// against a queue-based return-stack model; responses go through a scoreboard
// that a separate monitor drains on the response handshake.
module tb_call_ret_sequencer;

    localparam int AW = 19;
    localparam int D  = 16;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_call, req_ret;
    logic [AW-1:0] req_addr;
    logic          flush;
    logic          rsp_valid, rsp_ready;
    logic [AW-1:0] rsp_addr;
    logic          rsp_miss;
    logic          call, ret;
    logic [PW:0]   depth_cnt;
    logic          ovf;

    call_ret_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_call  (req_call),
        .req_ret   (req_ret),
        .req_addr  (req_addr),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_addr  (rsp_addr),
        .rsp_miss  (rsp_miss),
        .call      (call),
        .ret       (ret),
        .depth_cnt (depth_cnt),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: return stack (newest at back), busy flag, sticky ovf.
    logic [AW-1:0] stack[$];
    logic [AW:0]   exp_q[$];   // {miss, addr}
    bit            m_busy;
    bit            m_ovf;
    bit            exp_call;
    bit            exp_ret;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Response monitor: payload must match the scoreboard head every cycle it is
    // presented; the entry retires on a handshake not cancelled by flush.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response at %0t",
                         $time);
            end else begin
                check("rsp_addr", rsp_addr, exp_q[0][AW-1:0]);
                check("rsp_miss", rsp_miss, exp_q[0][AW]);
                if (rsp_ready && !flush) void'(exp_q.pop_front());
            end
        end
    end

    // One clock cycle; entered and left at posedge+1.
    task automatic step(input bit v, input bit c, input bit r, input logic [AW-1:0] a,
                        input bit f, input bit rr);
        bit acc;
        req_valid = v;
        req_call  = c;
        req_ret   = r;
        req_addr  = a;
        flush     = f;
        rsp_ready = rr;
        @(negedge clk);
        check("req_ready", req_ready, !m_busy && !f);
        check("rsp_valid", rsp_valid, m_busy);
        acc      = v && !m_busy && !f;
        exp_call = 1'b0;
        exp_ret  = 1'b0;
        if (f) begin
            stack.delete();
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (rr) m_busy = 1'b0;
        end else if (acc && c && !r) begin
            stack.push_back(a);
            if (stack.size() > D) begin
                void'(stack.pop_front());
                m_ovf = 1'b1;
            end
            exp_call = 1'b1;
        end else if (acc && r && !c) begin
            if (stack.size() > 0) begin
                exp_q.push_back({1'b0, stack.pop_back()});
                exp_ret = 1'b1;
            end else begin
                exp_q.push_back({1'b1, {AW{1'b0}}});
            end
            m_busy = 1'b1;
        end
        @(posedge clk);
        #1;
        if (f) exp_q.delete();
        check("call", call, exp_call);
        check("ret", ret, exp_ret);
        check("depth_cnt", depth_cnt, stack.size());
        check("ovf", ovf, m_ovf);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, 1);
    endtask

    // Asynchronous reset asserted mid-cycle; entered and left at posedge+1.
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_addr", rsp_addr, 0);
        check("rst_rsp_miss", rsp_miss, 0);
        check("rst_call", call, 0);
        check("rst_ret", ret, 0);
        check("rst_depth", depth_cnt, 0);
        check("rst_ovf", ovf, 0);
        stack.delete();
        exp_q.delete();
        m_busy = 1'b0;
        m_ovf  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, !flush);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_call  = 1'b0;
        req_ret   = 1'b0;
        req_addr  = '0;
        flush     = 1'b0;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        apply_reset();

        // CALL then RET of a single address.
        step(1, 1, 0, 19'h00100, 0, 1);
        idle(1);
        step(1, 0, 1, '0, 0, 1);
        idle(2);

        // RET on empty buffer.
        step(1, 0, 1, '0, 0, 1);
        idle(2);

        // Overflow: 17 pushes, 16 pops, then a miss.
        for (int i = 1; i <= 17; i++) step(1, 1, 0, AW'(i), 0, 1);
        for (int i = 0; i < 17; i++) begin
            step(1, 0, 1, '0, 0, 1);
            step(0, 0, 0, '0, 0, 1);
        end
        idle(1);

        // Held response with back-pressure; requests must be refused meanwhile.
        step(1, 1, 0, 19'h2A5A5, 0, 1);
        step(1, 0, 1, '0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 19'h11111, 0, 0);
        step(0, 0, 0, '0, 0, 1);
        idle(1);

        // Flush empties the buffer; ovf survives.
        for (int i = 0; i < 3; i++) step(1, 1, 0, AW'(32'h300 + i), 0, 1);
        step(1, 1, 0, 19'h7, 1, 1);
        step(1, 0, 1, '0, 0, 1);
        idle(2);

        // Simultaneous call+ret is dropped.
        step(1, 1, 0, 19'h00042, 0, 1);
        step(1, 1, 1, 19'h00099, 0, 1);
        idle(2);

        // Reset while a response is pending.
        step(1, 0, 1, '0, 0, 0);
        step(0, 0, 0, '0, 0, 0);
        apply_reset();
        idle(1);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            int unsigned kind;
            bit v, c, r, f, rr;
            kind = $urandom_range(7);
            v    = ($urandom_range(3) != 0);
            c    = (kind <= 3) || (kind == 7);
            r    = (kind >= 4);
            f    = ($urandom_range(39) == 0);
            rr   = ($urandom_range(2) != 0);
            step(v, c, r, AW'($urandom), f, rr);
        end

        idle(4);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
